// File: rtl/he_dft_pkg.sv
// Shared types and helpers for the DFT coefficient path: bank identifiers,
// output FIFO depth and a width-parameterised bit-reversal.
package he_dft_pkg;

    localparam int PP_FIFO_DEPTH = 2;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

    // Reverse the low `width` bits of value; higher result bits are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] rev;
        rev = {<<{value}};
        return rev >> (32 - width);
    endfunction

endpackage

// File: rtl/bram_pingpong_ctrl_if.sv
// Producer stream, consumer stream and shared two-bank BRAM port bundle for
// the ping-pong controller. The controller side uses the slave modport.
interface bram_pingpong_ctrl_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
);
    // Streams: a word transfers on a rising edge where valid && ready; the
    // sender holds valid and data stable until that edge, ready may toggle freely.
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [1:0]            bank_we;
    logic [ADDR_WIDTH-1:0] bank_waddr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [ADDR_WIDTH-1:0] bank_raddr;
    logic [DATA_WIDTH-1:0] bank_rdata0;
    logic [DATA_WIDTH-1:0] bank_rdata1;

    modport slave (
        input  in_valid, in_data, out_ready, bank_rdata0, bank_rdata1,
        output in_ready, out_valid, out_data, out_last,
               bank_we, bank_waddr, bank_wdata, bank_raddr
    );

    modport master (
        output in_valid, in_data, out_ready, bank_rdata0, bank_rdata1,
        input  in_ready, out_valid, out_data, out_last,
               bank_we, bank_waddr, bank_wdata, bank_raddr
    );
endinterface

// File: rtl/pp_out_fifo.sv
// Two-entry output FIFO carrying {last, data}. The push side has no ready:
// the controller only issues a BRAM read when a slot is guaranteed.
module pp_out_fifo
    import he_dft_pkg::*;
#(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [PP_FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign push        = push_valid_i;
    assign pop         = (count_q != 2'd0) && pop_ready_i;
    assign pop_valid_o = (count_q != 2'd0);
    assign pop_data_o  = pop_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong controller: fills one BRAM bank with a frame while draining the
// other through a 2-entry FIFO. Define BRAM_PP_BITREV_EN for bit-reversed reads.
module bram_pingpong_ctrl
    import he_dft_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input logic                clk,
    input logic                rst_n,
    bram_pingpong_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [1:0]            full_q, full_d;
    bank_e                 wr_sel_q, wr_sel_d;
    bank_e                 rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_last_q, infl_last_d;
    bank_e                 infl_bank_q, infl_bank_d;

    logic                  wr_hs;
    logic                  pop;
    logic                  issue;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] rdata_sel;

    assign bus.in_ready   = rst_n && !full_q[wr_sel_q];
    assign wr_hs          = bus.in_valid && bus.in_ready;
    assign bus.bank_waddr = wr_cnt_q;
    assign bus.bank_wdata = bus.in_data;

    always_comb begin
        bus.bank_we = 2'b00;
        if (wr_hs) bus.bank_we[wr_sel_q] = 1'b1;
    end

    // Slots committed after this edge: words held, plus the read in flight,
    // minus the word leaving now. A new read may issue only if one stays free.
    assign pop       = bus.out_valid && bus.out_ready;
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = full_q[rd_sel_q] && (occupancy < 3'(PP_FIFO_DEPTH));

`ifdef BRAM_PP_BITREV_EN
    assign bus.bank_raddr = ADDR_WIDTH'(bit_reverse(32'(rd_cnt_q), ADDR_WIDTH));
`else
    assign bus.bank_raddr = rd_cnt_q;
`endif

    always_comb begin
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        inflight_d  = issue;
        infl_last_d = issue && (rd_cnt_q == LAST_ADDR);
        infl_bank_d = rd_sel_q;

        if (wr_hs) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_ADDR) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = other_bank(wr_sel_q);
            end
        end

        // The reader and writer always sit on different banks, so these two
        // updates never touch the same full bit.
        if (issue) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_ADDR) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = other_bank(rd_sel_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            wr_sel_q    <= BANK0;
            rd_sel_q    <= BANK0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_bank_q <= BANK0;
        end else begin
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            infl_bank_q <= infl_bank_d;
        end
    end

    assign rdata_sel = (infl_bank_q == BANK1) ? bus.bank_rdata1 : bus.bank_rdata0;

    pp_out_fifo #(
        .W(DATA_WIDTH + 1)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (inflight_q),
        .push_data_i  ({infl_last_q, rdata_sel}),
        .pop_valid_o  (bus.out_valid),
        .pop_ready_i  (bus.out_ready),
        .pop_data_o   ({bus.out_last, bus.out_data}),
        .count_o      (fifo_count)
    );
endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Bench for bram_pingpong_ctrl with 8-word frames: a frame-level reference
// model feeds an expected queue that a separate output monitor consumes.
module tb_bram_pingpong_ctrl;
    localparam int DW = 18;
    localparam int AW = 3;
    localparam int N  = 1 << AW;
    localparam int W  = DW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bram_pingpong_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external BRAM banks (1-cycle registered read) ----------------
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];
    initial begin
        bus.bank_rdata0 = '0;
        bus.bank_rdata1 = '0;
    end
    always @(posedge clk) begin
        if (bus.bank_we[0]) mem0[bus.bank_waddr] <= bus.bank_wdata;
        if (bus.bank_we[1]) mem1[bus.bank_waddr] <= bus.bank_wdata;
        bus.bank_rdata0 <= mem0[bus.bank_raddr];
        bus.bank_rdata1 <= mem1[bus.bank_raddr];
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]  exp_q [$];
    logic [DW-1:0] cur_frame [$];
    int            model_bank = 0;

    function automatic int read_order(input int k);
        int r;
`ifdef BRAM_PP_BITREV_EN
        r = 0;
        for (int i = 0; i < AW; i++)
            if (((k >> i) & 1) == 1) r = r | (1 << (AW - 1 - i));
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d);
        cur_frame.push_back(d);
        if (cur_frame.size() == N) begin
            for (int k = 0; k < N; k++)
                exp_q.push_back({(k == N - 1), cur_frame[read_order(k)]});
            cur_frame.delete();
            model_bank = 1 - model_bank;
        end
    endtask

    // ---------------- consumer ready driver ----------------
    // mode 0: always ready, 1: never ready, 2: random 50%, 3: one-cycle stall on each last word
    int mode = 0;
    bit stall_done = 0;
    initial bus.out_ready = 1'b0;
    always @(posedge clk) begin
        #2;
        case (mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'b0;
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.out_valid && bus.out_last && !stall_done) begin
                    bus.out_ready = 1'b0;
                    stall_done    = 1'b1;
                end else begin
                    bus.out_ready = 1'b1;
                    if (!(bus.out_valid && bus.out_last)) stall_done = 1'b0;
                end
            end
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    longint       last_hs_cyc = 0;
    bit           lat_armed = 0;
    bit           bubble_armed = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_word = '0;
    logic [W-1:0] got;
    logic [W-1:0] exp_w;

    always @(negedge clk) begin
        if (rst_n) begin
            got = {bus.out_last, bus.out_data};
            check("fifo_count_le2", 64'(dut.u_fifo.count_o <= 2'd2), 64'd1);
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_word", 64'(got), 64'(prev_word));
            end
            if (lat_armed && bus.out_valid) begin
                check("first_out_latency", 64'(cyc - last_hs_cyc), 64'd3);
                lat_armed = 0;
            end
            if (bubble_armed) begin
                check("no_bubble_after_last", 64'(bus.out_valid), 64'd1);
                bubble_armed = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got=%0h expected=none", got);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_word", 64'(got), 64'(exp_w));
                    if (mode == 3 && bus.out_last && exp_q.size() > 0) bubble_armed = 1;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = got;
        end else begin
            prev_stall   = 0;
            bubble_armed = 0;
        end
    end

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit hs = 0;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!hs) begin
            @(negedge clk);
            if (bus.in_ready) begin
                hs = 1;
                check("wr_bank_we", 64'(bus.bank_we), 64'd1 << model_bank);
                check("wr_addr", 64'(bus.bank_waddr), 64'(cur_frame.size()));
                check("wr_data", 64'(bus.bank_wdata), 64'(d));
                last_hs_cyc = cyc;
                model_accept(d);
            end else if (++waited > 1000) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got=0 expected=1 after %0d cycles", waited);
                hs = 1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame_random(input int max_gap);
        for (int i = 0; i < N; i++) begin
            send_word(DW'($urandom_range(0, (1 << DW) - 1)));
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            tick();
            waited++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_q.delete();
        cur_frame.delete();
        model_bank = 0;
        @(negedge clk);
        check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("rst_we_low", 64'(bus.bank_we), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_out_last", 64'(bus.out_last), 64'd0);
        check("post_rst_out_data", 64'(bus.out_data), 64'd0);
        check("post_rst_bank_we", 64'(bus.bank_we), 64'd0);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        mode = 1;

        // Reset state
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_last", 64'(bus.out_last), 64'd0);
        check("reset_out_data", 64'(bus.out_data), 64'd0);
        check("reset_bank_we", 64'(bus.bank_we), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Single frame 0..N-1 with consumer always ready; latency check
        mode = 0;
        lat_armed = 1;
        for (int i = 0; i < N; i++) send_word(DW'(i));
        drain("drain_frame_seq");

        // Three frames with consumer blocked: writer must stall after two frames
        mode = 1;
        repeat (2) tick();
        for (int i = 0; i < 2 * N; i++) send_word(DW'($urandom_range(0, (1 << DW) - 1)));
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom_range(0, (1 << DW) - 1));
        repeat (10) begin
            @(negedge clk);
            check("both_full_in_ready", 64'(bus.in_ready), 64'd0);
            check("both_full_no_we", 64'(bus.bank_we), 64'd0);
        end
        tick();
        mode = 0;
        send_word(bus.in_data);
        for (int i = 1; i < N; i++) send_word(DW'($urandom_range(0, (1 << DW) - 1)));
        drain("drain_three_frames");

        // Random backpressure over 20 frames with random producer gaps
        mode = 2;
        for (int f = 0; f < 20; f++) send_frame_random(2);
        drain("drain_random");

        // Reset in the middle of the second frame
        mode = 1;
        send_frame_random(0);
        for (int i = 0; i < 3; i++) send_word(DW'($urandom_range(0, (1 << DW) - 1)));
        repeat (4) tick();
        pulse_reset();
        mode = 0;
        send_frame_random(1);
        drain("drain_after_reset");

        // One-cycle stall on each last word, next frame already buffered
        mode = 1;
        send_frame_random(0);
        send_frame_random(0);
        mode = 3;
        drain("drain_stall_last");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_pingpong_ctrl.md
Name: bram_pingpong_ctrl

Overview:
- Double-buffer (ping-pong) controller for two external 18-bit coefficient BRAM banks, each with 1-cycle registered read and one write port.
- Streams one frame of N = 2^ADDR_WIDTH coefficients into one bank while the other bank is drained, optionally in bit-reversed order, for the DFT stage.
- Sits between the coefficient producer and the butterfly datapath; valid/ready on both sides.

Parameters:
- DATA_WIDTH, 18, coefficient width.
- ADDR_WIDTH, 10, bank address width; frame length N = 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  DATA_WIDTH  producer word.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts.
- out_data  output  DATA_WIDTH  output word.
- out_last  output  1  marks final word of a frame.
- bank_we  output  2  per-bank write enable (bit b = bank b).
- bank_waddr  output  ADDR_WIDTH  write address, shared by both banks.
- bank_wdata  output  DATA_WIDTH  write data, shared.
- bank_raddr  output  ADDR_WIDTH  read address, shared.
- bank_rdata0  input  DATA_WIDTH  bank 0 registered read data.
- bank_rdata1  input  DATA_WIDTH  bank 1 registered read data.

Behaviour:
- State: full[1:0], wr_sel, rd_sel, wr_cnt, rd_cnt (ADDR_WIDTH each), 2-entry output FIFO, inflight flag, inflight_last flag.
- Reset: full=0, wr_sel=rd_sel=0, counters=0, FIFO empty, inflight=0; in_ready=0 during reset, then follows rule below; out_valid=0, out_last=0, out_data=0, bank_we=0. Bank contents untouched. Reset mid-frame discards the partial frame.
- Write side: in_ready = !full[wr_sel]. On handshake: bank_we[wr_sel]=1, bank_waddr=wr_cnt, bank_wdata=in_data (combinational pass-through), wr_cnt++. When wr_cnt==N-1 on handshake: full[wr_sel] set, wr_sel toggles, wr_cnt wraps to 0.
- Read side: issue when full[rd_sel] && (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready. Issue drives bank_raddr = addr(rd_cnt), rd_cnt++, inflight set next cycle with the bank id latched. When the issued rd_cnt==N-1: full[rd_sel] cleared and rd_sel toggled on that edge; inflight_last set.
- Next cycle, the selected bank_rdataX is pushed into the FIFO with its last flag.
- Latency: the last input handshake in cycle C gives the first out_valid in cycle C+3. Steady state is 1 word/cycle with out_ready=1.
- Throughput/backpressure: out_ready low never loses data. The FIFO never overflows by construction.
- Simultaneous: setting full[a] and clearing full[b] in the same cycle is legal. Writer may start the freed bank the cycle after the last read issue. Writer and reader never target the same bank.
- Both banks full: in_ready=0 until the reader issues the last address of rd_sel.
- out_data/out_last reflect the FIFO head; both hold while out_valid && !out_ready.

Optional Feature:
- Macro BRAM_PP_BITREV_EN.
- Defined: addr(rd_cnt) = bit-reversal of rd_cnt over ADDR_WIDTH bits.
- Undefined: addr(rd_cnt) = rd_cnt (natural order).
- The write order is natural in both cases.

Decomposition:
- Shared package he_dft_pkg: bit-reverse function (parameterised width), FIFO depth constant PP_FIFO_DEPTH=2, bank-select enum BANK0/BANK1.
- Sub-module pp_out_fifo: 2-entry valid/ready FIFO carrying {last, data}, count output, synchronous active-low reset.

Test Plan:
- ADDR_WIDTH=3, stream 0..7 with out_ready=1, no macro -> outputs 0..7, out_last on 7, first out_valid exactly 3 cycles after the input handshake of word 7.
- Same with BRAM_PP_BITREV_EN -> outputs 0,4,2,6,1,5,3,7, out_last on 7.
- Stream 3 frames back-to-back with out_ready=0 -> in_ready drops after 16 words (both banks full); release out_ready -> all 24 words are received in order with no loss or duplication.
- Random out_ready (50%) over 20 frames -> scoreboard matches exactly; FIFO count never exceeds 2.
- Assert rst_n=0 for 1 cycle mid-frame 2 -> all outputs return to reset values next cycle; a fresh frame then streams correctly from address 0.
- Consumer stall of exactly 1 cycle on out_last -> out_data/out_last held; next frame's first word follows with no bubble beyond the stall.
